halut_decoder_stream: RTL and testbench

- Streaming successor to the single-unit HALUT decoder: per-codebook LUT lookup (FP16) with FP32 accumulation.
- Adds a valid/ready input stream with an explicit `last` marker, so accumulation length is variable per row (1..C) instead of fixed at C.
- Adds an output FIFO with backpressure, a synchronous flush, and a sticky length-error flag.
- Sits between the encoder output stream and the downstream result collector/writeback; one instance per output column.

---
 rtl/halut_decoder_stream_if.sv | 45 ++++
 rtl/halut_decoder_stream.sv | 207 ++++++++++++++++++++
 tb/tb_halut_decoder_stream.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/halut_decoder_stream_if.sv
// Stream, LUT-write and status bundle for the streaming HALUT decoder.
// master: encoder/collector side; slave: the decoder.
interface halut_decoder_stream_if #(
   parameter int unsigned K             = 16,
   parameter int unsigned C             = 32,
   parameter int unsigned DataTypeWidth = 16
);
   localparam int unsigned TotalAddrWidth = $clog2(C * K);
   localparam int unsigned CAddrWidth     = $clog2(C);
   localparam int unsigned TreeDepth      = $clog2(K);

   logic [TotalAddrWidth-1:0] waddr_i;
   logic [DataTypeWidth-1:0]  wdata_i;
   logic                      we_i;
   logic                      in_valid_i;
   logic                      in_ready_o;
   logic [CAddrWidth-1:0]     c_addr_i;
   logic [TreeDepth-1:0]      k_addr_i;
   logic                      last_i;
   logic [CAddrWidth:0]       num_c_i;
   logic                      flush_i;
   logic                      out_valid_o;
   logic                      out_ready_i;
   logic [31:0]               result_o;
   logic                      err_o;
   logic                      err_clr_i;

   modport master (
      output waddr_i, wdata_i, we_i,
      output in_valid_i, c_addr_i, k_addr_i,
      output last_i, num_c_i, flush_i,
      output out_ready_i, err_clr_i,
      input  in_ready_o, out_valid_o,
      input  result_o, err_o
   );

   modport slave (
      input  waddr_i, wdata_i, we_i,
      input  in_valid_i, c_addr_i, k_addr_i,
      input  last_i, num_c_i, flush_i,
      input  out_ready_i, err_clr_i,
      output in_ready_o, out_valid_o,
      output result_o, err_o
   );
endinterface

// File: rtl/halut_decoder_stream.sv
// Streaming HALUT decoder: FP16 LUT lookup per beat, FP32 row accumulation,
// output FIFO with backpressure, sync flush and sticky row-length error.
// Ports: clk_i, rst_ni (async, active-low), bus (slave modport: LUT write,
// beat stream in, result stream out, flush, err_o/err_clr_i).
module halut_decoder_stream #(
   parameter int unsigned K              = 16,
   parameter int unsigned C              = 32,
   parameter int unsigned DataTypeWidth  = 16,
   parameter int unsigned OutFifoDepth   = 2,
   parameter int unsigned TotalAddrWidth = $clog2(C * K),
   parameter int unsigned CAddrWidth     = $clog2(C),
   parameter int unsigned TreeDepth      = $clog2(K)
) (
   input logic                   clk_i,
   input logic                   rst_ni,
   halut_decoder_stream_if.slave bus
);
   localparam int unsigned PtrW  = (OutFifoDepth > 1) ? $clog2(OutFifoDepth) : 1;
   localparam int unsigned CntW  = $clog2(OutFifoDepth + 1) + 1;
   localparam int unsigned BeatW = CAddrWidth + 1;

   function automatic logic [31:0] fp16_to_32(input logic [15:0] h);
      logic [7:0]  e;
      logic [23:0] f;
      e = 8'd0;
      f = {1'b0, h[9:0], 13'd0};
      if (h[14:10] == 5'h1F) begin
         e = 8'hFF;
      end else if (h[14:10] != 5'd0) begin
         e = {3'd0, h[14:10]} + 8'd112;
      end else if (h[9:0] != 10'd0) begin
         // Subnormal FP16 becomes a normal FP32: shift up to the hidden bit.
         e = 8'd113;
         for (int i = 0; i < 11; i++) begin
            if (!f[23]) begin
               f = f << 1;
               e = e - 8'd1;
            end
         end
      end
      return {h[15], e, f[22:0]};
   endfunction

   function automatic logic [31:0] fp32_add(input logic [31:0] x,
                                            input logic [31:0] y);
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  ea;
      logic [7:0]  eb;
      logic [7:0]  d;
      logic [27:0] ma;
      logic [27:0] mb;
      logic [27:0] mr;
      logic [9:0]  er;
      logic [24:0] mt;
      logic        st;
      logic        rnd;
      if (x[30:0] >= y[30:0]) begin
         a = x;
         b = y;
      end else begin
         a = y;
         b = x;
      end
      if (a[30:23] == 8'hFF) begin
         if (a[22:0] != 23'd0) return a | 32'h0040_0000;
         if (b[30:23] == 8'hFF && a[31] != b[31]) return 32'h7FC0_0000;
         return a;
      end
      ea = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
      eb = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
      ma = {1'b0, a[30:23] != 8'd0, a[22:0], 3'b000};
      mb = {1'b0, b[30:23] != 8'd0, b[22:0], 3'b000};
      d  = ea - eb;
      if (d >= 8'd28) begin
         st = |mb;
         mb = '0;
      end else begin
         st = |(mb & ((28'd1 << d) - 28'd1));
         mb = mb >> d;
      end
      mb[0] = mb[0] | st;
      mr = (a[31] == b[31]) ? ma + mb : ma - mb;
      if (mr == 28'd0) return {a[31] & b[31], 31'd0};
      er = {2'b00, ea};
      if (mr[27]) begin
         mr = {1'b0, mr[27:2], mr[1] | mr[0]};
         er = er + 10'd1;
      end
      for (int i = 0; i < 27; i++) begin
         if (!mr[26] && er > 10'd1) begin
            mr = mr << 1;
            er = er - 10'd1;
         end
      end
      // Round to nearest even on guard/round/sticky.
      rnd = mr[2] & (mr[3] | mr[1] | mr[0]);
      mt  = {1'b0, mr[26:3]} + {24'd0, rnd};
      if (mt[24]) begin
         mt = mt >> 1;
         er = er + 10'd1;
      end
      if (er >= 10'd255) return {a[31], 8'hFF, 23'd0};
      return {a[31], mt[23] ? er[7:0] : 8'd0, mt[22:0]};
   endfunction

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(OutFifoDepth - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [DataTypeWidth-1:0]  lut_q [C*K];
   logic [TotalAddrWidth-1:0] raddr;
   logic [DataTypeWidth-1:0]  rdata;

   logic                      s1_valid_q;
   logic                      s1_last_q;
   logic [DataTypeWidth-1:0]  s1_data_q;
   logic [31:0]               acc_q;
   logic [31:0]               acc_d;
   logic [BeatW-1:0]          beat_q;
   logic [BeatW-1:0]          beat_nxt;
   logic                      err_q;
   logic                      err_d;
   logic [31:0]               fifo_q [OutFifoDepth];
   logic [PtrW-1:0]           wr_ptr_q;
   logic [PtrW-1:0]           rd_ptr_q;
   logic [CntW-1:0]           count_q;

   logic in_ready;
   logic accept;
   logic row_end;
   logic len_err;
   logic push;
   logic pop;

   assign raddr = TotalAddrWidth'({bus.c_addr_i, bus.k_addr_i});
   assign rdata = lut_q[raddr];

   always_ff @(posedge clk_i) begin
      if (bus.we_i) lut_q[bus.waddr_i] <= bus.wdata_i;
   end

   // Reserve a slot for a last beat already in stage 1 so it can always push.
   assign in_ready = (count_q + CntW'(s1_valid_q & s1_last_q))
                     < CntW'(OutFifoDepth);
   assign accept   = bus.in_valid_i & in_ready & ~bus.flush_i;
   assign beat_nxt = beat_q + 1'b1;
   // A full C-beat row without last closes the row implicitly.
   assign row_end  = bus.last_i | (beat_nxt == BeatW'(C));
   assign len_err  = accept &
                     ((bus.last_i & (beat_nxt != bus.num_c_i)) |
                      (~bus.last_i & (beat_nxt == BeatW'(C))));

   assign acc_d = fp32_add(fp16_to_32(s1_data_q), acc_q);
   assign push  = s1_valid_q & s1_last_q;
   assign pop   = bus.out_valid_o & bus.out_ready_i;

   always_comb begin
      err_d = err_q;
      if (bus.err_clr_i) err_d = 1'b0;
      if (len_err)       err_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_data_q  <= '0;
         acc_q      <= '0;
         beat_q     <= '0;
         err_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < OutFifoDepth; i++) fifo_q[i] <= '0;
      end else begin
         err_q <= err_d;
         if (bus.flush_i) begin
            s1_valid_q <= 1'b0;
            acc_q      <= '0;
            beat_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
         end else begin
            s1_valid_q <= accept;
            if (accept) begin
               s1_data_q <= rdata;
               s1_last_q <= row_end;
               beat_q    <= row_end ? '0 : beat_nxt;
            end
            if (s1_valid_q) acc_q <= s1_last_q ? '0 : acc_d;
            if (push) begin
               fifo_q[wr_ptr_q] <= acc_d;
               wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CntW'(push) - CntW'(pop);
         end
      end
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = (count_q != '0);
   assign bus.result_o    = fifo_q[rd_ptr_q];
   assign bus.err_o       = err_q;
endmodule

// File: tb/tb_halut_decoder_stream.sv
// Scoreboard bench for halut_decoder_stream: directed rows push expected
// sums; a negedge monitor pops and compares on every output handshake.
module tb_halut_decoder_stream;
   localparam int K  = 16;
   localparam int C  = 32;
   localparam int DW = 16;
   localparam int D  = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   halut_decoder_stream_if #(.K(K), .C(C), .DataTypeWidth(DW)) bus ();

   halut_decoder_stream #(
      .K(K), .C(C), .DataTypeWidth(DW), .OutFifoDepth(D)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int stalls = 0;
   logic [31:0] expq[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h want none", bus.result_o);
         end else begin
            chk("row_result", bus.result_o, expq.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int c, input int k, input bit last, input int nc);
      int n;
      bit r;
      n = 0;
      bus.in_valid_i = 1'b1;
      bus.c_addr_i   = 5'(c);
      bus.k_addr_i   = 4'(k);
      bus.last_i     = last;
      bus.num_c_i    = 6'(nc);
      forever begin
         @(negedge clk);
         r = bus.in_ready_o;
         step();
         if (r) break;
         stalls++;
         n++;
         if (n > 200) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got stall want accept");
            break;
         end
      end
      bus.in_valid_i = 1'b0;
      bus.last_i     = 1'b0;
   endtask

   task automatic row10();
      for (int j = 0; j < 4; j++) beat(j, 5, j == 3, 4);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (expq.size() != 0 && n < 200) begin
         step();
         n++;
      end
   endtask

   initial begin
      bus.waddr_i     = '0;
      bus.wdata_i     = '0;
      bus.we_i        = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.c_addr_i    = '0;
      bus.k_addr_i    = '0;
      bus.last_i      = 1'b0;
      bus.num_c_i     = '0;
      bus.flush_i     = 1'b0;
      bus.out_ready_i = 1'b1;
      bus.err_clr_i   = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
      chk("rst_result", bus.result_o, 32'd0);
      chk("rst_err", 32'(bus.err_o), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      for (int i = 0; i < C * K; i++) begin
         bus.we_i    = 1'b1;
         bus.waddr_i = 9'(i);
         bus.wdata_i = 16'h3C00;
         step();
      end
      bus.we_i = 1'b0;

      // 32 x 1.0 with explicit last
      expq.push_back(32'h4200_0000);
      for (int i = 0; i < 32; i++) beat(i, i % 16, i == 31, 32);
      @(negedge clk);
      chk("lat_cycle1_valid", 32'(bus.out_valid_o), 32'd0);
      @(negedge clk);
      chk("lat_cycle2_valid", 32'(bus.out_valid_o), 32'd1);
      chk("t1_err", 32'(bus.err_o), 32'd0);
      step();
      drain();

      // k=5 entries 1,2,3,4 -> rows of 10.0
      for (int c = 0; c < 4; c++) begin
         bus.we_i    = 1'b1;
         bus.waddr_i = 9'(c * 16 + 5);
         bus.wdata_i = (c == 0) ? 16'h3C00 : (c == 1) ? 16'h4000 :
                       (c == 2) ? 16'h4200 : 16'h4400;
         step();
      end
      bus.we_i = 1'b0;
      stalls = 0;
      repeat (3) expq.push_back(32'h4120_0000);
      repeat (3) row10();
      chk("b2b_no_bubble", 32'(stalls), 32'd0);
      drain();

      // backpressure with consumer stalled
      bus.out_ready_i = 1'b0;
      repeat (3) expq.push_back(32'h4120_0000);
      repeat (2) row10();
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready_low", 32'(bus.in_ready_o), 32'd0);
         chk("bp_out_valid", 32'(bus.out_valid_o), 32'd1);
         chk("bp_head_stable", bus.result_o, 32'h4120_0000);
      end
      step();
      bus.out_ready_i = 1'b1;
      row10();
      drain();

      // short row: last on beat 3 of 4 -> 6.0 and error
      expq.push_back(32'h40C0_0000);
      for (int j = 0; j < 3; j++) beat(j, 5, j == 2, 4);
      @(negedge clk);
      chk("err_short_row", 32'(bus.err_o), 32'd1);
      step();
      bus.err_clr_i = 1'b1;
      step();
      bus.err_clr_i = 1'b0;
      @(negedge clk);
      chk("err_cleared", 32'(bus.err_o), 32'd0);
      step();
      expq.push_back(32'h4040_0000);
      beat(0, 5, 1'b0, 4);
      bus.err_clr_i = 1'b1;
      beat(1, 5, 1'b1, 4);
      bus.err_clr_i = 1'b0;
      @(negedge clk);
      chk("err_set_wins", 32'(bus.err_o), 32'd1);
      step();
      bus.err_clr_i = 1'b1;
      step();
      bus.err_clr_i = 1'b0;

      // 32 beats, no last: implicit last with error
      expq.push_back(32'h4200_0000);
      for (int i = 0; i < 32; i++) beat(i, 0, 1'b0, 32);
      @(negedge clk);
      chk("err_implicit_last", 32'(bus.err_o), 32'd1);
      step();
      bus.err_clr_i = 1'b1;
      step();
      bus.err_clr_i = 1'b0;
      drain();

      // flush mid-row with one result held
      bus.out_ready_i = 1'b0;
      expq.push_back(32'h4120_0000);
      row10();
      beat(0, 5, 1'b0, 4);
      beat(1, 5, 1'b0, 4);
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      void'(expq.pop_back());
      @(negedge clk);
      chk("flush_out_valid", 32'(bus.out_valid_o), 32'd0);
      step();
      bus.out_ready_i = 1'b1;
      expq.push_back(32'h4120_0000);
      row10();
      drain();
      chk("flush_err_kept", 32'(bus.err_o), 32'd0);

      // LUT write racing a read of the same entry
      expq.push_back(32'h4000_0000);
      expq.push_back(32'h4040_0000);
      bus.we_i    = 1'b1;
      bus.waddr_i = 9'd0;
      bus.wdata_i = 16'h4000;
      beat(0, 0, 1'b0, 2);
      bus.we_i = 1'b0;
      beat(1, 0, 1'b1, 2);
      beat(0, 0, 1'b0, 2);
      beat(1, 0, 1'b1, 2);
      drain();

      chk("queue_drained", 32'(expq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
